// File: rtl/sw_seq_feeder.sv
// Host-side feeder for the Smith-Waterman systolic core: buffers S/T symbols, streams them as one
// contiguous valid burst, then waits (bounded) for the core's finish pulse and captures its score.
module sw_seq_feeder #(
  parameter int unsigned SEQ_LEN = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [11:0]       score,
  output logic              sw_valid,
  output logic [1:0]        sw_data_s,
  output logic [1:0]        sw_data_t,
  input  logic              sw_finish,
  input  logic [11:0]       sw_max
);

  localparam int unsigned BufAw = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned IdxW  = $clog2(SEQ_LEN + 1);
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StWait} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [1:0]      buf_s_q [SEQ_LEN];
  logic [1:0]      buf_t_q [SEQ_LEN];

  logic             wr_ok;
  logic [BufAw-1:0] rd_addr;

  // A write colliding with an accepted start is dropped so the run sees stable data.
  assign wr_ok   = (state_q == StIdle) && wr_en && !start && (32'(wr_addr) < SEQ_LEN);
  assign rd_addr = idx_q[BufAw-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SEQ_LEN; i++) begin
        buf_s_q[i] <= 2'd0;
        buf_t_q[i] <= 2'd0;
      end
    end else if (wr_ok) begin
      if (wr_sel) begin
        buf_t_q[wr_addr[BufAw-1:0]] <= wr_data;
      end else begin
        buf_s_q[wr_addr[BufAw-1:0]] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      score       <= 12'd0;
      sw_valid    <= 1'b0;
      sw_data_s   <= 2'd0;
      sw_data_t   <= 2'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StStream;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            sw_valid    <= 1'b1;
            sw_data_s   <= buf_s_q[0];
            sw_data_t   <= buf_t_q[0];
            idx_q       <= IdxW'(1);
          end
        end
        StStream: begin
          if (idx_q == IdxW'(SEQ_LEN)) begin
            state_q    <= StWait;
            sw_valid   <= 1'b0;
            sw_data_s  <= 2'd0;
            sw_data_t  <= 2'd0;
            wait_cnt_q <= '0;
          end else begin
            sw_data_s <= buf_s_q[rd_addr];
            sw_data_t <= buf_t_q[rd_addr];
            idx_q     <= idx_q + IdxW'(1);
          end
        end
        StWait: begin
          // Finish takes priority over a timeout landing on the same edge.
          if (sw_finish) begin
            state_q <= StIdle;
            score   <= sw_max;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else if (wait_cnt_q == CntW'(TIMEOUT)) begin
            state_q     <= StIdle;
            score       <= 12'd0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Directed bench for sw_seq_feeder: stream order, stub finish, timeout, ignored inputs and
// mid-stream reset, with a stub core driven from the bench.
module tb_sw_seq_feeder;

  localparam int unsigned SeqLen  = 256;
  localparam int unsigned AddrW   = 9;
  localparam int unsigned Timeout = 1023;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic             wr_sel = 1'b0;
  logic [AddrW-1:0] wr_addr = '0;
  logic [1:0]       wr_data = 2'd0;
  logic             start = 1'b0;
  logic             busy, done, timeout_err, sw_valid;
  logic [11:0]      score;
  logic [1:0]       sw_data_s, sw_data_t;
  logic             sw_finish = 1'b0;
  logic [11:0]      sw_max = 12'd0;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_s [SeqLen];
  logic [1:0] exp_t [SeqLen];

  always #5 clk = ~clk;

  sw_seq_feeder #(
    .SEQ_LEN(SeqLen),
    .ADDR_W (AddrW),
    .TIMEOUT(Timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .score      (score),
    .sw_valid   (sw_valid),
    .sw_data_s  (sw_data_s),
    .sw_data_t  (sw_data_t),
    .sw_finish  (sw_finish),
    .sw_max     (sw_max)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input int unsigned addr, input logic [1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AddrW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Optionally collides a write to S[1] with the accepted start; it must be dropped.
  task automatic begin_run(input bit clash_write);
    start = 1'b1;
    if (clash_write) begin
      wr_en   = 1'b1;
      wr_sel  = 1'b0;
      wr_addr = AddrW'(1);
      wr_data = 2'd0;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic stream(input int inject_at, input int reset_at);
    for (int k = 0; k < int'(SeqLen); k++) begin
      if (k == reset_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", sw_valid, 0);
        chk("rst_data", {sw_data_s, sw_data_t}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < int'(SeqLen); i++) begin
          exp_s[i] = 2'd0;
          exp_t[i] = 2'd0;
        end
        return;
      end
      chk("stream_valid", sw_valid, 1);
      chk("stream_s", sw_data_s, exp_s[k]);
      chk("stream_t", sw_data_t, exp_t[k]);
      chk("stream_busy", busy, 1);
      if (k == inject_at) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = 2'd3;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
    end
    chk("end_valid", sw_valid, 0);
    chk("end_data", {sw_data_s, sw_data_t}, 0);
    chk("end_busy", busy, 1);
    chk("end_done", done, 0);
  endtask

  task automatic wait_quiet(input int n);
    int seen = 0;
    repeat (n) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b1) seen++;
    end
    chk("wait_quiet", seen, 0);
  endtask

  task automatic finish_run(input logic [11:0] v);
    sw_finish = 1'b1;
    sw_max    = v;
    tick();
    sw_finish = 1'b0;
    sw_max    = 12'h000;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_score", score, v);
    chk("fin_terr", timeout_err, 0);
    tick();
    chk("fin_done_drop", done, 0);
    chk("fin_score_hold", score, v);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_terr0", timeout_err, 0);
    chk("rst_score0", score, 0);
    chk("rst_valid0", sw_valid, 0);
    chk("rst_ds0", sw_data_s, 0);
    chk("rst_dt0", sw_data_t, 0);

    // Finish from the core while idle must not touch score.
    sw_finish = 1'b1;
    sw_max    = 12'h7ff;
    tick();
    sw_finish = 1'b0;
    chk("idle_fin_score", score, 0);
    chk("idle_fin_done", done, 0);

    for (int k = 0; k < int'(SeqLen); k++) begin
      exp_s[k] = 2'(k % 4);
      exp_t[k] = 2'(3 - (k % 4));
      wr(1'b0, k, exp_s[k]);
      wr(1'b1, k, exp_t[k]);
    end
    // Out of range: would alias S[44] if the range check were missing.
    wr(1'b0, 300, 2'd3);

    // Ordering run with start/write injected mid-stream, stub finish on WAIT cycle 384.
    begin_run(1'b0);
    stream(10, -1);
    wait_quiet(383);
    finish_run(12'h123);

    // Timeout run; also replays S[0] and S[1] after dropped writes.
    begin_run(1'b1);
    stream(-1, -1);
    wait_quiet(Timeout);
    tick();
    chk("to_done", done, 1);
    chk("to_terr", timeout_err, 1);
    chk("to_score", score, 0);
    chk("to_busy", busy, 0);
    tick();
    chk("to_done_drop", done, 0);
    chk("to_terr_sticky", timeout_err, 1);

    // Finish on the same edge the counter reaches the limit: finish wins.
    begin_run(1'b0);
    chk("start_clears_terr", timeout_err, 0);
    stream(-1, -1);
    wait_quiet(Timeout);
    finish_run(12'habc);

    // Finish in the very first WAIT cycle.
    begin_run(1'b0);
    stream(-1, -1);
    finish_run(12'h5a5);

    // Integration-style data set with the expected core score supplied by the stub.
    for (int k = 0; k < int'(SeqLen); k++) begin
      exp_s[k] = 2'd0;
      exp_t[k] = (k < 100) ? 2'd0 : 2'd1;
      wr(1'b0, k, exp_s[k]);
      wr(1'b1, k, exp_t[k]);
    end
    begin_run(1'b0);
    stream(-1, -1);
    wait_quiet(20);
    finish_run(12'd800);

    // Reset mid-stream, then a replay must stream cleared buffers.
    begin_run(1'b0);
    stream(-1, 50);
    chk("post_rst_score", score, 0);
    begin_run(1'b0);
    stream(-1, -1);
    finish_run(12'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
